// File: rtl/seq_playback_ctrl.sv
// -----------------------------------------------------------------------------
// seq_playback_ctrl
// Plays the "show" phase of the Simon game. On start it reads the sequence
// memory from step 0 up to the latched round length. Each step lights its LED
// for ON_TICKS game ticks, then stays dark for OFF_TICKS ticks. When the last
// step finishes it pulses done for one cycle.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-low reset
//   tick       one-cycle game-rate enable
//   start      playback request; only accepted in IDLE
//   abort      cancel playback; returns to IDLE without done
//   round_len  number of steps to play, latched at start, clamped to DEPTH
//   rd_addr    sequence memory address (taken directly from idx)
//   rd_data    sequence memory data, valid one cycle after rd_addr
//   led        one-hot lit LED; 0 when dark
//   busy       high in every state except IDLE
//   done       one-cycle completion pulse
//   step_idx   current step index (taken directly from idx)
// -----------------------------------------------------------------------------
module seq_playback_ctrl #(
   parameter int DEPTH     = 16,
   parameter int ADDR_W    = 4,
   parameter int ON_TICKS  = 2,
   parameter int OFF_TICKS = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tick,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W:0]   round_len,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [1:0]        rd_data,
   output logic [3:0]        led,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] step_idx
);

   localparam int MAX_TICKS = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
   localparam int CNT_W     = $clog2(MAX_TICKS + 1);

   localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [CNT_W-1:0] ON_L    = CNT_W'(ON_TICKS);
   localparam logic [CNT_W-1:0] OFF_L   = CNT_W'(OFF_TICKS);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LATCH,
      S_ON,
      S_GAP,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] idx_q,   idx_d;
   logic [ADDR_W:0]   len_q,   len_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   logic [3:0]        led_q,   led_d;
   logic              busy_q,  busy_d;
   logic              done_q,  done_d;

   logic [ADDR_W:0]   len_clamped;
   logic              last_step;

   // round_len wider than the memory is clamped so idx can never wrap.
   assign len_clamped = (round_len > DEPTH_L) ? DEPTH_L : round_len;

   // len_q >= 1 whenever this is used (zero length skips straight to DONE).
   assign last_step = ({1'b0, idx_q} == (len_q - 1'b1));

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      led_d   = led_q;

      if (abort) begin
         // Abort outranks everything, including start in IDLE and tick.
         state_d = S_IDLE;
         idx_d   = '0;
         cnt_d   = '0;
         led_d   = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               led_d = '0;
               idx_d = '0;
               if (start) begin
                  len_d   = len_clamped;
                  state_d = (len_clamped == '0) ? S_DONE : S_FETCH;
               end
            end

            // rd_addr is held on idx for one cycle; data arrives in LATCH.
            S_FETCH: state_d = S_LATCH;

            S_LATCH: begin
               led_d   = 4'b0001 << rd_data;
               cnt_d   = ON_L;
               state_d = S_ON;
            end

            S_ON: begin
               if (tick) begin
                  if (cnt_q == CNT_ONE) begin
                     led_d   = '0;
                     cnt_d   = OFF_L;
                     state_d = S_GAP;
                  end else begin
                     cnt_d = cnt_q - CNT_ONE;
                  end
               end
            end

            S_GAP: begin
               if (tick) begin
                  cnt_d = cnt_q - CNT_ONE;
                  if (cnt_q == CNT_ONE) begin
                     if (last_step) begin
                        state_d = S_DONE;
                     end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_FETCH;
                     end
                  end
               end
            end

            S_DONE: begin
               idx_d   = '0;
               state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
         endcase
      end

      // Registered status tracks the state being entered, so busy and done
      // line up with the state they describe.
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         led_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         led_q   <= led_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign rd_addr  = idx_q;
   assign step_idx = idx_q;
   assign led      = led_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_seq_playback_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for seq_playback_ctrl. Playback requests push the expected
// (step, colour) sequence followed by a done marker. A monitor pops an entry
// each time an LED lights or done pulses. It also measures lit and dark
// durations in ticks.
// -----------------------------------------------------------------------------
module tb_seq_playback_ctrl;

   localparam int DEPTH     = 16;
   localparam int ADDR_W    = 4;
   localparam int ON_TICKS  = 2;
   localparam int OFF_TICKS = 1;
   localparam int BUDGET    = 5000;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              tick = 1'b0;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic [ADDR_W:0]   round_len = '0;
   logic [ADDR_W-1:0] rd_addr;
   logic [1:0]        rd_data;
   logic [3:0]        led;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] step_idx;

   int checks = 0;
   int errors = 0;
   int tick_mode = 0;  // 0: every 10 cycles, 1: continuous, 2: random

   logic [1:0] mem [DEPTH];
   int exp_q [$];      // entry = step*4 + colour, or -1 for done

   seq_playback_ctrl #(
      .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ON_TICKS(ON_TICKS), .OFF_TICKS(OFF_TICKS)
   ) dut (
      .clk(clk), .reset(reset), .tick(tick), .start(start), .abort(abort),
      .round_len(round_len), .rd_addr(rd_addr), .rd_data(rd_data), .led(led),
      .busy(busy), .done(done), .step_idx(step_idx)
   );

   always #5 clk = ~clk;

   // Synchronous-read sequence memory.
   always @(posedge clk) rd_data <= mem[rd_addr];

   initial begin : tick_gen
      int ph;
      ph = 0;
      forever begin
         @(posedge clk);
         #1;
         ph = (ph + 1) % 10;
         case (tick_mode)
            0:       tick = (ph == 0);
            1:       tick = 1'b1;
            default: tick = ($urandom_range(0, 3) == 0);
         endcase
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- monitor
   initial begin : monitor
      int   item;
      bit   prev_lit, lit, in_gap, p1, p2;
      int   lit_ticks, lit_cyc, dark_ticks, dark_cyc;
      logic [3:0] cur_led;
      prev_lit = 0; in_gap = 0; p1 = 0; p2 = 0;
      lit_ticks = 0; lit_cyc = 0; dark_ticks = 0; dark_cyc = 0; cur_led = '0;
      forever begin
         @(negedge clk);
         if (!busy) begin
            prev_lit = 0;
            in_gap   = 0;
            continue;
         end
         if (done) begin
            item = (exp_q.size() > 0) ? exp_q.pop_front() : -99;
            chk("done_expected", item, -1);
            chk("led_dark_at_done", int'(led), 0);
            if (in_gap) chk("gap_ticks_final", dark_ticks, OFF_TICKS);
            prev_lit = 0;
            in_gap   = 0;
            continue;
         end
         lit = (led != 4'b0000);
         if (lit && !prev_lit) begin
            item = (exp_q.size() > 0) ? exp_q.pop_front() : -99;
            chk("led_value", int'(led), (item >= 0) ? (1 << (item % 4)) : 0);
            chk("step_idx", int'(step_idx), (item >= 0) ? item / 4 : -1);
            chk("rd_addr", int'(rd_addr), (item >= 0) ? item / 4 : -1);
            if (in_gap) begin
               // last two dark cycles are FETCH and LATCH; their ticks do not count
               chk("gap_ticks", dark_ticks - int'(p1) - int'(p2), OFF_TICKS);
               if (tick_mode == 1) chk("dark_cycles", dark_cyc, OFF_TICKS + 2);
            end
            lit_ticks = int'(tick);
            lit_cyc   = 1;
            cur_led   = led;
         end else if (lit) begin
            if (led != cur_led) chk("led_stable", int'(led), int'(cur_led));
            lit_ticks += int'(tick);
            lit_cyc++;
         end else if (prev_lit) begin
            chk("on_ticks", lit_ticks, ON_TICKS);
            if (tick_mode == 1) chk("on_cycles", lit_cyc, ON_TICKS);
            in_gap     = 1;
            dark_ticks = int'(tick);
            dark_cyc   = 1;
            p1 = tick;
            p2 = 0;
         end else if (in_gap) begin
            dark_ticks += int'(tick);
            dark_cyc++;
            p2 = p1;
            p1 = tick;
         end
         prev_lit = lit;
      end
   end

   // --------------------------------------------------------------- stimulus
   task automatic randomize_mem();
      for (int i = 0; i < DEPTH; i++) mem[i] = 2'($urandom_range(0, 3));
   endtask

   task automatic push_expected(input int rlen);
      int len;
      len = (rlen > DEPTH) ? DEPTH : rlen;
      for (int i = 0; i < len; i++) exp_q.push_back(i * 4 + int'(mem[i]));
      exp_q.push_back(-1);
   endtask

   task automatic issue_start(input int rlen);
      @(negedge clk);
      start     = 1'b1;
      round_len = (ADDR_W+1)'(rlen);
      @(negedge clk);
      start     = 1'b0;
      round_len = (ADDR_W+1)'($urandom_range(0, 31));  // must be ignored
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      if (n >= BUDGET) chk({name, "_timeout"}, n, 0);
      chk({name, "_sb_drained"}, exp_q.size(), 0);
   endtask

   task automatic run_play(input int rlen, input bit poke_start, input string name);
      push_expected(rlen);
      issue_start(rlen);
      if (poke_start) begin
         repeat ($urandom_range(3, 40)) @(negedge clk);
         if (busy) begin
            start     = 1'b1;
            round_len = (ADDR_W+1)'($urandom_range(1, 31));
            @(negedge clk);
            start = 1'b0;
         end
      end
      wait_idle(name);
   endtask

   // Waits (from a negedge) until the given step is lit; returns with led lit.
   task automatic wait_lit_step(input int idx, input string name);
      int n;
      n = 0;
      while (!(led != 4'b0000 && int'(step_idx) == idx) && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      if (n >= BUDGET) chk({name, "_wait_lit_timeout"}, n, 0);
   endtask

   initial begin : stim
      int n, busy_cnt;
      randomize_mem();

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_led", int'(led), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_rd_addr", int'(rd_addr), 0);
      chk("rst_step_idx", int'(step_idx), 0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Basic playback
      tick_mode = 0;
      mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3; mem[3] = 2'd1;
      run_play(4, 1'b0, "basic");
      chk("basic_busy_after", int'(busy), 0);

      // Zero length: done in the single busy cycle, then idle
      exp_q.push_back(-1);
      issue_start(0);
      chk("zero_busy", int'(busy), 1);
      chk("zero_done", int'(done), 1);
      chk("zero_led", int'(led), 0);
      @(negedge clk);
      chk("zero_busy_after", int'(busy), 0);
      chk("zero_done_after", int'(done), 0);
      chk("zero_sb_drained", exp_q.size(), 0);

      // Clamp and full depth
      randomize_mem();
      run_play(31, 1'b0, "clamp31");
      randomize_mem();
      run_play(DEPTH, 1'b1, "full16");

      // Random lengths, random ticks, start pokes while busy
      tick_mode = 2;
      for (int r = 0; r < 4; r++) begin
         randomize_mem();
         run_play($urandom_range(1, 20), 1'b1, "rand");
      end

      // Tick held high
      tick_mode = 1;
      for (int r = 0; r < 3; r++) begin
         randomize_mem();
         run_play($urandom_range(1, 17), 1'b1, "cont");
      end

      // Abort during ON of step 1
      tick_mode = 0;
      randomize_mem();
      push_expected(4);
      issue_start(4);
      wait_lit_step(1, "abort");
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      exp_q.delete();
      chk("abort_led", int'(led), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_step_idx", int'(step_idx), 0);
      busy_cnt = 0;
      repeat (30) begin
         @(negedge clk);
         busy_cnt += int'(busy) + int'(done);
      end
      chk("abort_stays_idle", busy_cnt, 0);

      // Start and abort together in IDLE
      start = 1'b1; abort = 1'b1; round_len = 5'd3;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      busy_cnt = 0;
      repeat (6) begin
         busy_cnt += int'(busy) + int'(led != 4'b0000);
         @(negedge clk);
      end
      chk("start_abort_idle", busy_cnt, 0);

      // Reset during GAP of step 2, then replay from step 0
      randomize_mem();
      push_expected(5);
      issue_start(5);
      wait_lit_step(2, "rstmid");
      n = 0;
      while (led != 4'b0000 && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      if (n >= BUDGET) chk("rstmid_gap_timeout", n, 0);
      reset = 1'b0;
      exp_q.delete();
      @(negedge clk);
      reset = 1'b1;
      chk("rstmid_led", int'(led), 0);
      chk("rstmid_busy", int'(busy), 0);
      chk("rstmid_done", int'(done), 0);
      chk("rstmid_rd_addr", int'(rd_addr), 0);
      chk("rstmid_step_idx", int'(step_idx), 0);
      repeat (3) begin
         @(negedge clk);
         chk("rstmid_no_done", int'(done), 0);
      end
      run_play(4, 1'b0, "replay");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
